lms_filter_core: RTL
====================

Name: lms_filter_core

Overview:
- Parametrised successor to the fixed 4-tap LMS `top` block; adaptive FIR with NTAPS taps, configurable data/weight width, fixed-point weights and shift-based step size.
- Adds valid/ready input handshake, an output-valid strobe and a run-time freeze (adapt_en) mode.
- Adds a weight-clear request and indexed weight readback for the bench and debug logic.
- Uses a single shared MAC, time-multiplexed over the taps by an FSM.

Parameters:
- NTAPS, 4: number of taps (≥2).
- DW, 16: signed width of x_in, d_in, y_out, e_out.
- WW, 16: signed weight width.
- FRAC, 8: fractional bits of the weights. y = acc >>> FRAC.
- MU_SHIFT, 4: step size is 2^-MU_SHIFT.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; one clock, reset asynchronous and active-low.
- in_valid  in  1  sample offered.
- in_ready  out  1  core can accept a sample.
- x_in  in  DW  signed input sample.
- d_in  in  DW  signed desired sample.
- adapt_en  in  1  sampled at accept: 1 = update weights, 0 = freeze.
- weights_clear  in  1  single-cycle request to zero all weights.
- out_valid  out  1  one-cycle strobe; y_out and e_out are new.
- y_out  out  DW  filter output, saturated.
- e_out  out  DW  error d − y, saturated.
- w_rd_idx  in  clog2(NTAPS)+1  weight readback index.
- w_rd_data  out  WW  weights[w_rd_idx], combinational; 0 if idx ≥ NTAPS.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; delay line, weights, y_out, e_out, accumulator, out_valid and pending-clear all 0.
  - in_ready forced 0 while rst=0.
- Delay line x[0..NTAPS-1]: x[0] is the newest sample.
- Accept = IDLE && in_valid && in_ready.
  - On accept, the delay line shifts (x[0]←x_in); d_in and adapt_en are latched.
- in_ready = (state==IDLE) && !clear_pending.
- States:
  - IDLE: waits for accept, then goes to MAC.
  - MAC: NTAPS cycles, tap i processed in the i-th cycle; acc += w[i]*x[i].
    - Product width DW+WW; acc width DW+WW+clog2(NTAPS); no overflow possible.
  - ERR: 1 cycle.
    - ysat = sat_DW(acc >>> FRAC), arithmetic shift.
    - esat = sat_DW(d − ysat), computed at DW+1 bits.
    - Both are registered to y_out and e_out at the end of ERR; acc is cleared.
    - Next state is UPD if adapt is latched, else IDLE.
  - UPD: NTAPS cycles; w[i] ← sat_WW(w[i] + ((e_out*x[i]) >>> MU_SHIFT)).
    - e_out is the saturated error; it is used for all taps.
    - Returns to IDLE after the last tap.
- out_valid is high exactly one cycle: the cycle after ERR, i.e. the first UPD cycle or the first IDLE cycle.
- Timing for an accept at edge T:
  - MAC occupies T+1..T+NTAPS; ERR is T+NTAPS+1; out_valid is high at T+NTAPS+2.
  - Next accept possible at T+2·NTAPS+2 (adapt) or T+NTAPS+2 (freeze).
- sat_N clamps to [−2^(N−1), 2^(N−1)−1].
- weights_clear:
  - In IDLE with no accept in the same cycle: all weights are zeroed on the next edge.
  - Otherwise clear_pending is set. It is applied on the first IDLE cycle, where in_ready=0 for that one cycle, then pending is cleared.
  - If clear and accept coincide in IDLE, the accept wins and the clear is deferred.
  - Clear never alters the delay line, y_out or e_out.
- in_valid while busy: ignored. No buffering; the source must hold in_valid until the handshake.
- Reset mid-operation: immediate return to the reset state. A partially updated weight set is discarded (zeroed).

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release → in_ready=1; out_valid=0; w_rd_data=0 for idx 0..3; y_out=e_out=0.
- First sample (defaults), accept at T with x=256, d=512, adapt=1 → y_out=0 and e_out=512 with out_valid at T+6 only; weights {8192,0,0,0}; in_ready high again at T+10.
- Second sample x=256, d=512, adapt=1 → y_out=8192, e_out=−7680; weights saturate to {−32768,−32768,0,0}.
- Freeze plus saturation: x=32767, d=0, adapt=0 → y_out=−32768, e_out=32767; weights unchanged; in_ready back at T+6.
- Clear: pulse weights_clear during MAC → weights intact until IDLE; then in_ready=0 for one cycle and all weights read 0; w_rd_idx=5 → 0.
- Reset mid-UPD: assert rst in the 2nd UPD cycle → outputs and weights read 0 immediately (asynchronous); first post-reset sample behaves as in the first-sample scenario.

Source files
------------

// File: rtl/lms_filter_core.sv
//==============================================================================
// Module      : lms_filter_core
// Description : Adaptive LMS FIR filter with NTAPS taps. A single shared MAC is
//               time-multiplexed over the taps (MAC phase, then ERR, then an
//               optional UPD phase). Valid/ready input handshake, output strobe,
//               run-time freeze, deferred weight clear and weight readback.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module lms_filter_core #(
  parameter int NTAPS    = 4,
  parameter int DW       = 16,
  parameter int WW       = 16,
  parameter int FRAC     = 8,
  parameter int MU_SHIFT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DW-1:0]     x_in,
  input  logic signed [DW-1:0]     d_in,
  input  logic                     adapt_en,
  input  logic                     weights_clear,
  output logic                     out_valid,
  output logic signed [DW-1:0]     y_out,
  output logic signed [DW-1:0]     e_out,
  input  logic [$clog2(NTAPS):0]   w_rd_idx,
  output logic signed [WW-1:0]     w_rd_data
);

  localparam int CW = $clog2(NTAPS);
  localparam int IW = $clog2(NTAPS) + 1;
  localparam int PW = DW + WW;
  localparam int AW = PW + $clog2(NTAPS);
  localparam int EW = 2 * DW;
  localparam int SW = ((EW > WW) ? EW : WW) + 1;

  localparam logic [CW-1:0] c_LAST  = CW'(NTAPS - 1);
  localparam logic [IW-1:0] c_NTAPS = IW'(NTAPS);

  // Saturation bounds, written as bit patterns so they are width-exact.
  localparam logic signed [AW-1:0] c_Y_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] c_Y_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [DW:0]   c_E_MAX = {2'b00, {(DW-1){1'b1}}};
  localparam logic signed [DW:0]   c_E_MIN = {2'b11, {(DW-1){1'b0}}};
  localparam logic signed [SW-1:0] c_W_MAX = {{(SW-WW+1){1'b0}}, {(WW-1){1'b1}}};
  localparam logic signed [SW-1:0] c_W_MIN = {{(SW-WW+1){1'b1}}, {(WW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_ERR  = 2'd2,
    S_UPD  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          tap_q;
  logic signed [DW-1:0]   x_q [NTAPS];
  logic signed [WW-1:0]   w_q [NTAPS];
  logic signed [DW-1:0]   d_q;
  logic                   adapt_q;
  logic signed [AW-1:0]   acc_q;
  logic signed [DW-1:0]   y_q, e_q;
  logic                   ov_q;
  logic                   clr_pend_q;

  logic                   accept;
  logic signed [DW-1:0]   x_sel;
  logic signed [WW-1:0]   w_sel;
  logic signed [PW-1:0]   mac_prod;
  logic signed [AW-1:0]   acc_shr;
  logic signed [DW-1:0]   y_sat, e_sat;
  logic signed [DW:0]     e_wide;
  logic signed [EW-1:0]   upd_prod;
  logic signed [SW-1:0]   w_sum;
  logic signed [WW-1:0]   w_sat;

  // A clear that is waiting for IDLE steals that one IDLE cycle from the source.
  assign in_ready  = rst && (state_q == S_IDLE) && !clr_pend_q;
  assign out_valid = ov_q;
  assign y_out     = y_q;
  assign e_out     = e_q;
  assign w_rd_data = (w_rd_idx < c_NTAPS) ? w_q[w_rd_idx[CW-1:0]] : '0;

  // Shared arithmetic: MAC product, output/error saturation and weight update.
  always_comb begin
    x_sel    = x_q[tap_q];
    w_sel    = w_q[tap_q];
    mac_prod = x_sel * w_sel;
    acc_shr  = acc_q >>> FRAC;
    if (acc_shr > c_Y_MAX)      y_sat = c_Y_MAX[DW-1:0];
    else if (acc_shr < c_Y_MIN) y_sat = c_Y_MIN[DW-1:0];
    else                        y_sat = acc_shr[DW-1:0];
    e_wide = (DW+1)'(d_q) - (DW+1)'(y_sat);
    if (e_wide > c_E_MAX)       e_sat = c_E_MAX[DW-1:0];
    else if (e_wide < c_E_MIN)  e_sat = c_E_MIN[DW-1:0];
    else                        e_sat = e_wide[DW-1:0];
    // The update uses the registered (already saturated) error for every tap.
    upd_prod = e_q * x_sel;
    w_sum    = SW'(w_sel) + SW'(upd_prod >>> MU_SHIFT);
    if (w_sum > c_W_MAX)        w_sat = c_W_MAX[WW-1:0];
    else if (w_sum < c_W_MIN)   w_sat = c_W_MIN[WW-1:0];
    else                        w_sat = w_sum[WW-1:0];
  end

  // Next-state logic; freeze mode skips the UPD phase entirely.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          accept  = 1'b1;
          state_d = S_MAC;
        end
      end
      S_MAC:   if (tap_q == c_LAST) state_d = S_ERR;
      S_ERR:   state_d = adapt_q ? S_UPD : S_IDLE;
      S_UPD:   if (tap_q == c_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Tap index walks 0..NTAPS-1 in MAC and UPD, resting at 0 elsewhere.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tap_q <= '0;
    end else if (state_q == S_MAC || state_q == S_UPD) begin
      tap_q <= (tap_q == c_LAST) ? '0 : tap_q + 1'b1;
    end
  end

  // Datapath: delay line, accumulator, result registers, weights and clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        x_q[i] <= '0;
        w_q[i] <= '0;
      end
      d_q        <= '0;
      adapt_q    <= 1'b0;
      acc_q      <= '0;
      y_q        <= '0;
      e_q        <= '0;
      ov_q       <= 1'b0;
      clr_pend_q <= 1'b0;
    end else begin
      ov_q <= 1'b0;
      if (accept) begin
        x_q[0] <= x_in;
        for (int i = 1; i < NTAPS; i++) x_q[i] <= x_q[i-1];
        d_q     <= d_in;
        adapt_q <= adapt_en;
      end
      if (state_q == S_MAC) acc_q <= acc_q + AW'(mac_prod);
      if (state_q == S_ERR) begin
        y_q   <= y_sat;
        e_q   <= e_sat;
        acc_q <= '0;
        ov_q  <= 1'b1;
      end
      if (state_q == S_UPD) w_q[tap_q] <= w_sat;
      // A coinciding accept wins over a clear; the clear then waits for IDLE.
      if (state_q == S_IDLE && clr_pend_q) begin
        for (int i = 0; i < NTAPS; i++) w_q[i] <= '0;
        clr_pend_q <= 1'b0;
      end else if (state_q == S_IDLE && weights_clear && !accept) begin
        for (int i = 0; i < NTAPS; i++) w_q[i] <= '0;
      end else if (weights_clear) begin
        clr_pend_q <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
